// File: rtl/updown_counter_arbiter.sv
// Round-robin arbiter that lends one external loadable up/down counter to NREQ
// requesters, sequencing it through load -> count -> hold and returning the final value.
module updown_counter_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_start,
    input  logic [NREQ-1:0]         req_dir,
    input  logic [NREQ*WIDTH-1:0]   req_steps,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        result,
    output logic                    cnt_load,
    output logic                    cnt_mode,
    output logic [WIDTH-1:0]        cnt_din,
    input  logic [WIDTH-1:0]        cnt_out
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    last_q, last_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;

    logic [WIDTH-1:0] start_arr [NREQ];
    logic [WIDTH-1:0] steps_arr [NREQ];
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign start_arr[g] = req_start[g*WIDTH +: WIDTH];
        assign steps_arr[g] = req_steps[g*WIDTH +: WIDTH];
    end

    // Search starts one past the last granted requester, wrapping around.
    always_comb begin : arbitrate
        logic [IW-1:0] cand;
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last_q) + i) % NREQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NREQ - 1);
            start_q <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            start_q <= start_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        start_d = start_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gidx_d          = pick_idx;
                    start_d         = start_arr[pick_idx];
                    rem_d           = steps_arr[pick_idx];
                    dir_d           = req_dir[pick_idx];
                    state_d         = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (rem_q != '0) ? S_COUNT : S_DONE;
            end
            S_COUNT: begin
                rem_d = rem_q - 1'b1;
                if (rem_q == WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                last_d  = gidx_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outside COUNT the counter is reloaded with its own value, which holds it.
    always_comb begin
        cnt_load = 1'b1;
        cnt_mode = 1'b0;
        cnt_din  = cnt_out;
        done     = '0;
        result   = '0;
        if (!rst) begin
            cnt_din = '0;
        end else begin
            case (state_q)
                S_LOAD: cnt_din = start_q;
                S_COUNT: begin
                    cnt_load = 1'b0;
                    cnt_mode = dir_q;
                    cnt_din  = start_q;
                end
                S_DONE: begin
                    done   = gnt_q;
                    result = cnt_out;
                end
                default: ;
            endcase
        end
    end

    assign gnt = gnt_q;

endmodule

// File: tb/tb_updown_counter_arbiter.sv
// Directed bench for updown_counter_arbiter with a behavioural model of the shared counter.
module tb_updown_counter_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_start;
    logic [NREQ-1:0]       req_dir;
    logic [NREQ*WIDTH-1:0] req_steps;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  cnt_load;
    logic                  cnt_mode;
    logic [WIDTH-1:0]      cnt_din;
    logic [WIDTH-1:0]      cnt_q;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int r;
        int start;
        int dir;
        int steps;
        int exp;
    } job_t;

    job_t jobs [6];

    updown_counter_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_start (req_start),
        .req_dir   (req_dir),
        .req_steps (req_steps),
        .gnt       (gnt),
        .done      (done),
        .result    (result),
        .cnt_load  (cnt_load),
        .cnt_mode  (cnt_mode),
        .cnt_din   (cnt_din),
        .cnt_out   (cnt_q)
    );

    always #5 clk = ~clk;

    // External counter: no enable, reset tied to ~rst.
    always_ff @(posedge clk) begin
        if (!rst)          cnt_q <= 4'd0;
        else if (cnt_load) cnt_q <= cnt_din;
        else if (cnt_mode) cnt_q <= cnt_q + 4'd1;
        else               cnt_q <= cnt_q - 4'd1;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("gnt_onehot0", int'($onehot0(gnt)), 1);
        check("done_in_gnt", int'(done & ~gnt), 0);
    endtask

    task automatic run_job(input int r, input int s, input int d, input int n, input int e);
        bit got;
        int lat;
        req                        = '0;
        req[r]                     = 1'b1;
        req_start[r*WIDTH +: WIDTH] = 4'(s);
        req_dir[r]                 = d[0];
        req_steps[r*WIDTH +: WIDTH] = 4'(n);
        step();
        check("gnt_rise", int'(gnt), 1 << r);
        // Fields changed after grant must be ignored.
        req                        = '0;
        req_start[r*WIDTH +: WIDTH] = ~4'(s);
        req_dir[r]                 = ~d[0];
        req_steps[r*WIDTH +: WIDTH] = 4'hF;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            step();
            if (done != '0) begin
                got = 1'b1;
                lat = k;
            end else begin
                check("gnt_held", int'(gnt), 1 << r);
            end
        end
        if (!got) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_latency", lat, n + 1);
            check("done_bit", int'(done), 1 << r);
            check("done_gnt", int'(gnt), 1 << r);
            check("result", int'(result), e);
            check("done_load", int'(cnt_load), 1);
        end
        step();
        check("idle_gnt", int'(gnt), 0);
        check("idle_done", int'(done), 0);
        check("idle_result", int'(result), 0);
    endtask

    initial begin
        jobs[0] = '{r: 0, start: 3,  dir: 1, steps: 5, exp: 8};
        jobs[1] = '{r: 1, start: 2,  dir: 0, steps: 4, exp: 14};
        jobs[2] = '{r: 0, start: 14, dir: 1, steps: 3, exp: 1};
        jobs[3] = '{r: 1, start: 9,  dir: 1, steps: 0, exp: 9};
        jobs[4] = '{r: 0, start: 0,  dir: 0, steps: 1, exp: 15};
        jobs[5] = '{r: 1, start: 15, dir: 1, steps: 1, exp: 0};

        rst       = 1'b0;
        req       = 2'b11;
        req_start = 8'h5A;
        req_dir   = 2'b11;
        req_steps = 8'h33;
        step();
        step();
        check("rst_gnt", int'(gnt), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_load", int'(cnt_load), 1);
        check("rst_din", int'(cnt_din), 0);
        check("rst_mode", int'(cnt_mode), 0);
        check("rst_cnt", int'(cnt_q), 0);

        rst = 1'b1;
        req = '0;
        step();
        check("idle_after_rst_gnt", int'(gnt), 0);

        foreach (jobs[i]) begin
            run_job(jobs[i].r, jobs[i].start, jobs[i].dir, jobs[i].steps, jobs[i].exp);
        end

        // Zero-step job, then counter must hold its value through idle cycles.
        run_job(0, 9, 1, 0, 9);
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold_cnt", int'(cnt_q), 9);
            check("hold_load", int'(cnt_load), 1);
            check("hold_gnt", int'(gnt), 0);
        end

        // Round-robin with both requests held; reset first so requester 0 leads.
        req       = 2'b11;
        req_start = {4'd5, 4'd1};
        req_dir   = 2'b01;
        req_steps = {4'd1, 4'd1};
        rst       = 1'b0;
        step();
        check("rr_rst_gnt", int'(gnt), 0);
        rst = 1'b1;
        for (int g = 0; g < 4; g++) begin
            step();
            check("rr_gnt", int'(gnt), 1 << (g % 2));
            step();
            check("rr_no_early_done", int'(done), 0);
            step();
            check("rr_done", int'(done), 1 << (g % 2));
            check("rr_result", int'(result), (g % 2 == 0) ? 2 : 4);
            if (g == 3) req = '0;
            step();
            check("rr_idle_gnt", int'(gnt), 0);
        end

        // Reset during the third COUNT cycle of a long job.
        req       = 2'b01;
        req_start = {4'd0, 4'd0};
        req_dir   = 2'b01;
        req_steps = {4'd0, 4'd10};
        step();
        check("mid_gnt", int'(gnt), 1);
        req = '0;
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_load", int'(cnt_load), 1);
        check("mid_rst_din", int'(cnt_din), 0);
        check("mid_rst_mode", int'(cnt_mode), 0);
        step();
        check("mid_after_gnt", int'(gnt), 0);
        check("mid_after_done", int'(done), 0);
        check("mid_after_cnt", int'(cnt_q), 0);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check("mid_no_done", int'(done), 0);
            check("mid_cnt_hold", int'(cnt_q), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
